spi_slave_if: RTL and testbench

- Serial front-end that sits directly upstream of the single-port RAM stage.
- Deserialises MOSI frames into 10-bit command/data words (`rx_data`, `rx_valid`), which drive the RAM's `din`/`rx_valid`.
- Captures the RAM's read response (`tx_data`, `tx_valid`) and serialises it back out on MISO.
- The system clock is the serial bit clock: one bit per `clk` rising edge while `SS_n` is low.

---
 rtl/spi_slave_if.sv | 106 ++++++++++
 tb/tb_spi_slave_if.sv | 131 +++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI slave front-end: deserialises MOSI frames into RAM command words and
// serialises the RAM read byte back out on MISO.
module spi_slave_if #(
   parameter int FRAME_W = 10,
   parameter int DATA_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               SS_n,
   input  logic               MOSI,
   output logic               MISO,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid
);

   typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
   // Sub-phase shared by the three frame states: receive, await RAM, shift out, hold.
   typedef enum logic [1:0] {PH_RX, PH_WAIT, PH_SHIFT, PH_HOLD} phase_t;

   state_t              state;
   phase_t              phase;
   logic [3:0]          cnt;
   logic [FRAME_W-2:0]  sh_in;
   logic [DATA_W-1:0]   sout;
   logic                rd_addr_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         phase           <= PH_RX;
         cnt             <= '0;
         sh_in           <= '0;
         sout            <= '0;
         rd_addr_pending <= 1'b0;
         MISO            <= 1'b0;
         rx_data         <= '0;
         rx_valid        <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state != IDLE && SS_n) begin
            // Abort: a partial frame is dropped, rx_data keeps its last value.
            state <= IDLE;
            phase <= PH_RX;
            cnt   <= '0;
            MISO  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  MISO <= 1'b0;
                  if (!SS_n) begin
                     state <= CHK_CMD;
                     phase <= PH_RX;
                     cnt   <= '0;
                  end
               end
               CHK_CMD: begin
                  cnt   <= '0;
                  phase <= PH_RX;
                  if (!MOSI)                state <= WRITE;
                  else if (rd_addr_pending) state <= READ_DATA;
                  else                      state <= READ_ADD;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  case (phase)
                     PH_RX: begin
                        sh_in <= {sh_in[FRAME_W-3:0], MOSI};
                        if (cnt == 4'(FRAME_W-1)) begin
                           rx_data  <= {sh_in, MOSI};
                           rx_valid <= 1'b1;
                           cnt      <= '0;
                           if (state == READ_ADD) rd_addr_pending <= 1'b1;
                           phase <= (state == READ_DATA) ? PH_WAIT : PH_HOLD;
                        end else begin
                           cnt <= cnt + 4'd1;
                        end
                     end
                     PH_WAIT: begin
                        if (tx_valid) begin
                           sout            <= tx_data;
                           rd_addr_pending <= 1'b0;
                           phase           <= PH_SHIFT;
                        end
                     end
                     PH_SHIFT: begin
                        MISO <= sout[DATA_W-1];
                        sout <= {sout[DATA_W-2:0], 1'b0};
                        if (cnt == 4'(DATA_W-1)) begin
                           cnt   <= '0;
                           phase <= PH_HOLD;
                        end else begin
                           cnt <= cnt + 4'd1;
                        end
                     end
                     PH_HOLD: MISO <= 1'b0;
                     default: phase <= PH_HOLD;
                  endcase
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised bench for spi_slave_if against a transaction-level model of
// frame reception, read-address tracking and MISO read-back.
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int n_chk  = 0;
   int n_fail = 0;

   logic [9:0] m_rx;
   bit         m_pend;

   always #5 clk = ~clk;

   spi_slave_if #(.FRAME_W(10), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One SS_n-low transaction: selector, nbits frame bits (10 = complete),
   // optional reset pulse after cycle rst_at, then one cycle of SS_n high.
   task automatic xfer(input bit sel, input logic [9:0] frm, input int nbits,
                       input logic [7:0] tx, input int rst_at);
      bit complete = (nbits == 10);
      bit rd       = complete && sel && m_pend;
      bit ra       = complete && sel && !m_pend;
      int len      = complete ? 22 : 2 + nbits;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         SS_n = 1'b0;
         if (c == 1)                MOSI = sel;
         else if (c >= 2 && c < 12) MOSI = frm[11-c];
         else                       MOSI = 1'($urandom);
         if (rd && c == 12) begin
            tx_valid = 1'b1;
            tx_data  = tx;
         end else begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
         end
         @(posedge clk); #1;
         if (complete && c == 11) begin
            m_rx = frm;
            if (ra) m_pend = 1'b1;
         end
         if (rd && c == 12) m_pend = 1'b0;
         chk("rx_valid", rx_valid, complete && c == 11);
         chk("rx_data", rx_data, m_rx);
         chk("miso", MISO, (rd && c >= 13 && c <= 20) ? tx[20-c] : 1'b0);
         if (c == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            m_rx   = '0;
            m_pend = 1'b0;
            chk("rst_miso", MISO, 1'b0);
            chk("rst_rx_valid", rx_valid, 1'b0);
            chk("rst_rx_data", rx_data, m_rx);
            break;
         end
      end
      @(negedge clk);
      SS_n     = 1'b1;
      rst_n    = 1'b1;
      tx_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle_rx_valid", rx_valid, 1'b0);
      chk("idle_miso", MISO, 1'b0);
      chk("idle_rx_data", rx_data, m_rx);
   endtask

   initial begin
      rst_n    = 1'b0;
      SS_n     = 1'b1;
      MOSI     = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      m_rx     = '0;
      m_pend   = 1'b0;
      #3;
      chk("reset_miso", MISO, 1'b0);
      chk("reset_rx_valid", rx_valid, 1'b0);
      chk("reset_rx_data", rx_data, 10'h000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      xfer(1'b0, 10'h0A5, 10, 8'h00, -1);   // write address
      xfer(1'b0, 10'h13C, 10, 8'h00, -1);   // write data
      xfer(1'b1, 10'h2A5, 10, 8'h00, -1);   // read address
      xfer(1'b1, 10'h300, 10, 8'hC3, -1);   // read data -> 1,1,0,0,0,0,1,1
      xfer(1'b0, 10'h155, 5,  8'h00, -1);   // aborted write
      xfer(1'b0, 10'h0F0, 10, 8'h00, -1);   // complete frame after abort
      xfer(1'b0, 10'h1E1, 10, 8'h00, -1);   // back-to-back pair
      xfer(1'b0, 10'h01E, 10, 8'h00, -1);
      xfer(1'b1, 10'h211, 10, 8'h00, -1);   // read address
      xfer(1'b1, 10'h300, 10, 8'hFF, 16);   // reset mid MISO shift
      xfer(1'b1, 10'h2AA, 10, 8'h00, -1);   // must be READ_ADD again
      xfer(1'b1, 10'h3FF, 10, 8'h5A, -1);

      for (int i = 0; i < 40; i++) begin
         int nb = ($urandom_range(0, 9) < 7) ? 10 : int'($urandom_range(0, 9));
         xfer(1'($urandom), 10'($urandom), nb, 8'($urandom), -1);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            MOSI = 1'($urandom);
            @(posedge clk); #1;
            chk("gap_rx_valid", rx_valid, 1'b0);
            chk("gap_miso", MISO, 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
